timer_controller: RTL
=====================

TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 SHALL have parameter ALARM_LEN, default 10, alarm duration in tick_1hz pulses (1..255).
REQ-002 SHALL have parameter MAX_MIN, default 99, highest settable minutes value (BCD-encodable, 1..99).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick_1hz  input  1  one-clk-cycle pulse, once per second.
REQ-006 SHALL have port btn_min  input  1  debounced one-cycle pulse, minute increment.
REQ-007 SHALL have port btn_sec  input  1  debounced one-cycle pulse, second increment.
REQ-008 SHALL have port btn_start  input  1  debounced one-cycle pulse, start/pause/acknowledge.
REQ-009 SHALL have port bcd_time  output  16  M1,M0,S1,S0 BCD digits, [15:12] down to [3:0], for the display multiplexer.
REQ-010 SHALL have port alarm  output  1  high while in ALARM.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port state_o  output  2  current state encoding, for debug.

Function
REQ-013 SHALL implement four states: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
REQ-014 In IDLE: btn_min SHALL increment minutes in BCD; MAX_MIN wraps to 00. Seconds SHALL NOT change.
REQ-015 In IDLE: btn_sec SHALL increment seconds in BCD; 59 wraps to 00 with no carry into minutes.
REQ-016 In IDLE: btn_min and btn_sec in the same cycle SHALL clear bcd_time to 0000.
REQ-017 In IDLE: btn_start SHALL enter RUN next cycle only if bcd_time != 0000; otherwise it is ignored.
REQ-018 In RUN: each tick_1hz SHALL decrement time by one second in BCD. S0 borrows from S1. Seconds 00 becomes 59 with a minute borrow.
REQ-019 In RUN: a tick that yields 0000 SHALL enter ALARM on the same edge. Ticks SHALL NOT decrement below 0000.
REQ-020 In RUN: btn_start SHALL enter PAUSE. btn_min and btn_sec SHALL be ignored.
REQ-021 In RUN: tick_1hz and btn_start in the same cycle SHALL apply the decrement. The next state is then ALARM if the result is 0000, else PAUSE.
REQ-022 The first decrement after entering RUN SHALL occur on the first tick_1hz strictly after the transition cycle.
REQ-023 In PAUSE: ticks SHALL be ignored and time held. btn_start SHALL resume RUN.
REQ-024 In PAUSE: btn_min and btn_sec in the same cycle SHALL clear time to 0000 and enter IDLE. Either one alone SHALL be ignored.
REQ-025 In ALARM: alarm=1 and bcd_time=0000. An internal 8-bit counter SHALL count ticks from 0.
REQ-026 In ALARM: any button pulse, or the counter reaching ALARM_LEN, SHALL enter IDLE. A button takes precedence if both occur in one cycle.
REQ-027 All outputs SHALL be registered or decoded only from registered state. Input-to-output latency SHALL be 1 clk.
REQ-028 No BCD digit SHALL ever leave its legal range: M digits 0-9; S1 0-5; S0 0-9.

Reset
REQ-029 Asserting reset SHALL asynchronously force IDLE, bcd_time=0000, alarm=0, running=0, state_o=0, and alarm counter=0.
REQ-030 Reset asserted mid-RUN or mid-ALARM SHALL discard the remaining time. Pulses coincident with deassertion SHALL be ignored.

Structure
REQ-031 A shared constants include (timer_defs) SHALL hold the state encodings, the digit limits (9, 5) and the bcd_time field positions.
REQ-032 Digit arithmetic SHALL live in one sub-module, bcd_mmss_step. It is combinational, maps time plus inc_min/inc_sec/dec to the next time, and outputs a zero flag.
REQ-033 The controller SHALL hold the FSM, the time register and the alarm counter. Its expected size is 150-300 RTL lines.

Verification
REQ-034 IDLE, 3x btn_min then 61x btn_sec -> bcd_time=0x0301. The seconds wrap does not carry.
REQ-035 Set 01:00, btn_start, 1 tick -> 0x0059. After 59 more ticks -> 0x0000, alarm=1, state_o=3.
REQ-036 Set 00:05, start, 2 ticks, then btn_start coincident with a tick -> PAUSE at 0x0002. 5 further ticks keep 0x0002. btn_start then resumes RUN.
REQ-037 In ALARM with ALARM_LEN=10, no buttons -> IDLE after exactly 10 ticks. A repeat run with btn_sec at tick 3 -> IDLE on the next cycle.
REQ-038 btn_start at 0000 in IDLE -> stays IDLE. MAX_MIN=99: 100x btn_min -> minutes 00.
REQ-039 Assert reset mid-RUN at 0x0130 -> outputs 0 immediately, without waiting for a clk edge. After release, tick pulses cause no change.

Source files
------------

// File: rtl/timer_defs_pkg.sv
// Shared constants for the countdown timer: state encodings, BCD digit limits
// and the bcd_time field layout.
package timer_defs_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned TIME_W    = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned S1_MAX    = 5;

  localparam int unsigned S0_LSB = 0;
  localparam int unsigned S1_LSB = 4;
  localparam int unsigned M0_LSB = 8;
  localparam int unsigned M1_LSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  // Field order matches bcd_time: M1 in the top nibble down to S0.
  typedef struct packed {
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
    logic [DIGIT_W-1:0] s1;
    logic [DIGIT_W-1:0] s0;
  } mmss_t;

endpackage

// File: rtl/bcd_mmss_step.sv
// Combinational MM:SS BCD arithmetic: minute/second increment with wrap,
// one-second decrement with borrow (saturating at 00:00), and a zero flag.
module bcd_mmss_step
  import timer_defs_pkg::*;
#(
  parameter int unsigned MAX_MIN = 99
) (
  input  mmss_t cur,
  input  logic  inc_min,
  input  logic  inc_sec,
  input  logic  dec,
  output mmss_t nxt,
  output logic  zero
);

  localparam logic [DIGIT_W-1:0] MAX_M1 = DIGIT_W'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MAX_M0 = DIGIT_W'(MAX_MIN % 10);
  localparam logic [DIGIT_W-1:0] D_TOP  = DIGIT_W'(DIGIT_MAX);
  localparam logic [DIGIT_W-1:0] S1_TOP = DIGIT_W'(S1_MAX);
  localparam logic [DIGIT_W-1:0] ONE    = DIGIT_W'(1);

  always_comb begin
    nxt = cur;
    if (inc_min && inc_sec) begin
      nxt = '0;
    end else begin
      if (inc_min) begin
        if (cur.m1 == MAX_M1 && cur.m0 == MAX_M0) begin
          nxt.m1 = '0;
          nxt.m0 = '0;
        end else if (cur.m0 == D_TOP) begin
          nxt.m0 = '0;
          nxt.m1 = cur.m1 + ONE;
        end else begin
          nxt.m0 = cur.m0 + ONE;
        end
      end
      // Seconds wrap 59 -> 00 without touching minutes.
      if (inc_sec) begin
        if (cur.s1 == S1_TOP && cur.s0 == D_TOP) begin
          nxt.s1 = '0;
          nxt.s0 = '0;
        end else if (cur.s0 == D_TOP) begin
          nxt.s0 = '0;
          nxt.s1 = cur.s1 + ONE;
        end else begin
          nxt.s0 = cur.s0 + ONE;
        end
      end
      if (dec && cur != '0) begin
        if (cur.s0 != '0) begin
          nxt.s0 = cur.s0 - ONE;
        end else begin
          nxt.s0 = D_TOP;
          if (cur.s1 != '0) begin
            nxt.s1 = cur.s1 - ONE;
          end else begin
            nxt.s1 = S1_TOP;
            if (cur.m0 != '0) begin
              nxt.m0 = cur.m0 - ONE;
            end else begin
              nxt.m0 = D_TOP;
              nxt.m1 = cur.m1 - ONE;
            end
          end
        end
      end
    end
  end

  assign zero = (nxt == '0);

endmodule

// File: rtl/timer_controller.sv
// Kitchen-style countdown timer: button-set MM:SS, run/pause on start,
// alarm for ALARM_LEN seconds once the count reaches 00:00.
module timer_controller
  import timer_defs_pkg::*;
#(
  parameter int unsigned ALARM_LEN = 10,
  parameter int unsigned MAX_MIN   = 99
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_min,
  input  logic              btn_sec,
  input  logic              btn_start,
  output logic [TIME_W-1:0] bcd_time,
  output logic              alarm,
  output logic              running,
  output logic [1:0]        state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  mmss_t            time_q;
  mmss_t            time_nxt;
  logic             time_zero;
  logic             cur_zero;
  logic             btn_any;
  logic             step_inc_min;
  logic             step_inc_sec;
  logic             step_dec;
  logic [CNT_W-1:0] alarm_cnt;
  logic             alarm_q;
  logic             running_q;

  // Edits only apply in IDLE; ticks only count down in RUN.
  assign step_inc_min = (state_q == ST_IDLE) && btn_min;
  assign step_inc_sec = (state_q == ST_IDLE) && btn_sec;
  assign step_dec     = (state_q == ST_RUN) && tick_1hz;
  assign cur_zero     = (time_q == '0);
  assign btn_any      = btn_min || btn_sec || btn_start;

  bcd_mmss_step #(
    .MAX_MIN (MAX_MIN)
  ) u_step (
    .cur     (time_q),
    .inc_min (step_inc_min),
    .inc_sec (step_inc_sec),
    .dec     (step_dec),
    .nxt     (time_nxt),
    .zero    (time_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      alarm_cnt <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          time_q <= time_nxt;
          // A start that lands together with a clear must not launch a zero run.
          if (btn_start && !cur_zero && !time_zero) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          time_q <= time_nxt;
          if (tick_1hz && time_zero) begin
            state_q   <= ST_ALARM;
            running_q <= 1'b0;
            alarm_q   <= 1'b1;
            alarm_cnt <= '0;
          end else if (btn_start) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (btn_min && btn_sec) begin
            time_q  <= '0;
            state_q <= ST_IDLE;
          end else if (btn_start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_ALARM: begin
          time_q <= '0;
          if (btn_any) begin
            state_q   <= ST_IDLE;
            alarm_q   <= 1'b0;
            alarm_cnt <= '0;
          end else if (tick_1hz) begin
            if (alarm_cnt == CNT_LAST) begin
              state_q   <= ST_IDLE;
              alarm_q   <= 1'b0;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_time[M1_LSB +: DIGIT_W] = time_q.m1;
  assign bcd_time[M0_LSB +: DIGIT_W] = time_q.m0;
  assign bcd_time[S1_LSB +: DIGIT_W] = time_q.s1;
  assign bcd_time[S0_LSB +: DIGIT_W] = time_q.s0;
  assign alarm                       = alarm_q;
  assign running                     = running_q;
  assign state_o                     = state_q;

endmodule
